// File: rtl/riscuin_fetch_pkg.sv
// Shared constants and sizing helpers for the RISCuin instruction fetch front end.
package riscuin_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int unsigned entry_width(input int unsigned addr_w);
    return 32 + addr_w;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two.
module instr_fifo
  import riscuin_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: issues word fetches ahead of decode, buffers
// {instr, pc} in order, and discards in-flight responses after a redirect.
module instr_prefetch_queue
  import riscuin_fetch_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        mem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  output logic                        instr_valid,
  output logic [31:0]                 instr,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
  input  logic                        instr_ready,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  output logic                        busy
);

  localparam int unsigned AW     = INSTR_ADDR_WIDTH;
  localparam int unsigned PTR_W  = clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = CNT_W + 4;
  localparam int unsigned EW     = entry_width(AW);

  logic [AW-1:0]     fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [EW-1:0]    q_rdata;
  logic [CNT_W-1:0] q_count, tag_count;
  logic             q_empty, q_full, tag_empty, tag_full;
  logic [AW-1:0]    tag_head;
  logic [CNT_W:0]   in_flight;
  logic             accept, rsp_any, rsp_drop, rsp_keep, consume, q_push;

  assign in_flight = {1'b0, q_count} + {1'b0, outst_q};
  assign mem_req   = !rst && en && !redirect && (in_flight < (CNT_W+1)'(DEPTH));
  assign mem_addr  = fetch_pc_q;
  assign accept    = mem_req && mem_ready;

  assign rsp_any  = mem_rvalid && ((drop_q != '0) || (outst_q != '0));
  assign rsp_drop = mem_rvalid && (drop_q != '0);
  assign rsp_keep = mem_rvalid && (drop_q == '0) && (outst_q != '0);
  assign q_push   = rsp_keep && !redirect;
  assign consume  = instr_valid && instr_ready && !redirect;

  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? q_rdata[EW-1 -: 32] : '0;
  assign instr_pc    = instr_valid ? q_rdata[AW-1:0] : '0;
  assign busy        = (outst_q != '0) || (drop_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      drop_d     = drop_q + DROP_W'(outst_q) - DROP_W'(rsp_any);
      outst_d    = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + AW'(1);
      outst_d = outst_q + CNT_W'(accept) - CNT_W'(rsp_keep);
      if (rsp_drop) drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  instr_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .wdata_i ({mem_rdata, tag_head}),
    .pop_i   (consume),
    .flush_i (redirect),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Tags are flushed on redirect, so only live requests hold tags; dropped
  // responses are accounted for by drop_q alone and never pop this FIFO.
  instr_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (fetch_pc_q),
    .pop_i   (q_push),
    .flush_i (redirect),
    .rdata_o (tag_head),
    .count_o (tag_count),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rvalid && (outst_q == '0) && (drop_q == '0)));
      assert (!(q_push && q_full));
      assert (!(accept && tag_full));
      assert (!(rsp_keep && tag_empty));
      assert (tag_count == outst_q);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench: in-order memory model with random latency and a
// transaction-level fetch model using redirect epochs.
module tb_instr_prefetch_queue;

  localparam int unsigned AW = 10;
  localparam int unsigned DEPTH = 4;

  logic          clk, rst, en, mem_req, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_addr, instr_pc, redirect_pc;
  logic [31:0]   mem_rdata, instr;
  logic          instr_valid, instr_ready, redirect, busy;

  instr_prefetch_queue #(.INSTR_ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(10'd0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int unsigned epoch; int unsigned due; } req_t;
  typedef struct { logic [31:0] d; logic [AW-1:0] pc; } ent_t;

  req_t          pend[$];
  ent_t          q[$];
  logic [AW-1:0] mpc;
  int unsigned   epoch, cyc, lat_min, lat_max, rdy_pct, dut_acc;
  int            checks, errors;

  function automatic logic [31:0] rd(input logic [AW-1:0] a);
    return 32'hAB00_0000 | {22'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit rst_v, input bit en_v, input bit ir_v,
                       input bit redir_v, input logic [AW-1:0] rpc_v);
    bit rv, exp_req, cons;
    int unsigned outn;
    @(negedge clk);
    rst = rst_v; en = en_v; instr_ready = ir_v; redirect = redir_v; redirect_pc = rpc_v;
    if (rst_v) begin
      pend.delete(); q.delete(); epoch++; mpc = '0;
    end
    rv = (pend.size() != 0) && (pend[0].due <= cyc);
    mem_rvalid = rv;
    mem_rdata  = rv ? rd(pend[0].addr) : $urandom();
    mem_ready  = ($urandom_range(99) < rdy_pct);
    #1;
    outn = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) outn++;
    exp_req = !rst_v && en_v && !redir_v && (q.size() + outn < DEPTH);
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, mpc);
    chk("instr_valid", instr_valid, q.size() != 0);
    chk("instr", instr, (q.size() != 0) ? q[0].d : 32'h0);
    chk("instr_pc", instr_pc, (q.size() != 0) ? q[0].pc : '0);
    chk("busy", busy, pend.size() != 0);
    if (mem_req && mem_ready) dut_acc++;
    @(posedge clk);
    if (!rst_v) begin
      cons = (q.size() != 0) && ir_v && !redir_v;
      if (rv) begin
        if (pend[0].epoch == epoch && !redir_v) q.push_back('{rd(pend[0].addr), pend[0].addr});
        void'(pend.pop_front());
      end
      if (cons) void'(q.pop_front());
      if (exp_req && mem_ready) begin
        pend.push_back('{mpc, epoch, cyc + $urandom_range(lat_max, lat_min)});
        mpc = mpc + AW'(1);
      end
      if (redir_v) begin
        q.delete(); epoch++; mpc = rpc_v;
      end
    end
    cyc++;
  endtask

  int unsigned acc0;

  initial begin
    checks = 0; errors = 0; epoch = 0; cyc = 0; dut_acc = 0; mpc = '0;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    rst = 1'b1; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, then streaming fetch with 1-cycle memory
    repeat (3) cycle(1, 1, 1, 0, '0);
    repeat (12) cycle(0, 1, 1, 0, '0);

    // Reset mid-operation with 3-cycle memory and a stalled decoder
    lat_min = 3; lat_max = 3;
    repeat (3) cycle(0, 1, 0, 0, '0);
    cycle(1, 1, 1, 0, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    cycle(1, 1, 0, 0, '0);

    // Decoder stall right after reset: exactly DEPTH requests
    lat_min = 1; lat_max = 1;
    acc0 = dut_acc;
    repeat (10) cycle(0, 1, 0, 0, '0);
    chk("stall_accepts", dut_acc - acc0, DEPTH);
    chk("stall_head_pc", instr_pc, 10'd0);
    repeat (8) cycle(0, 1, 1, 0, '0);

    // 3-cycle memory, redirect with requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 1, 10'h100);
    repeat (12) cycle(0, 1, 1, 0, '0);

    // Redirect coinciding with a response and a consume
    lat_min = 1; lat_max = 1;
    repeat (6) cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 1, 10'h200);
    repeat (6) cycle(0, 1, 1, 0, '0);

    // Address wrap
    cycle(0, 1, 1, 1, 10'h3FF);
    repeat (8) cycle(0, 1, 1, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        lat_max = $urandom_range(4, 1);
        rdy_pct = $urandom_range(100, 40);
      end
      cycle(0, $urandom_range(9) != 0, $urandom_range(3) != 0,
            $urandom_range(19) == 0, AW'($urandom));
    end

    // Drain with fetch disabled
    lat_min = 1; lat_max = 4;
    repeat (25) cycle(0, 0, 1, 0, '0);
    chk("drain_busy", busy, 1'b0);
    chk("drain_valid", instr_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
